mag_window_stats: RTL and testbench

Downstream consumer of the vector-magnitude stage. It accepts 8-bit magnitude samples, keeps a sliding window of the last DEPTH samples in a ring buffer, and reports the windowed mean, the peak since the last clear, and a hysteresis threshold alarm. Its results feed the top-level output mux and status pins.

---
 rtl/mag_pkg.sv | 20 ++
 rtl/mag_ring_buf.sv | 46 ++++
 rtl/mag_window_stats.sv | 111 +++++++++++
 tb/tb_mag_window_stats.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mag_pkg.sv
// Shared definitions for the magnitude window statistics slice:
// default sample width, window FSM state encoding and a clog2 helper.
package mag_pkg;

  localparam int unsigned MAG_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2 for constant sizing; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mag_ring_buf.sv
// Ring buffer of the last DEPTH samples.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous pointer clear
//   wr_en       write wr_data at the pointer and advance it
//   wr_data     sample to store
//   old_mag_c   combinational read of the entry at the pointer (oldest sample),
//               pre-write value in the cycle of a write
module mag_ring_buf
  import mag_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned MAG_W = mag_pkg::MAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [MAG_W-1:0] wr_data,
  output logic [MAG_W-1:0] old_mag_c
);

  localparam int unsigned L = clog2(DEPTH);

  logic [MAG_W-1:0] mem [DEPTH];
  logic [L-1:0]     wr_ptr;

  // Pointer wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + L'(1);
    end
  end

  // Storage is not reset; stale entries are masked by the FILL state upstream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign old_mag_c = mem[wr_ptr];

endmodule

// File: rtl/mag_window_stats.sv
// Sliding-window statistics on magnitude samples: windowed mean, peak since
// clear and a hysteresis alarm evaluated on each mean update.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   clr              synchronous clear of window, fill, peak and alarm
//   in_valid, in_mag sample strobe and value (always ready)
//   thr_hi, thr_lo   alarm set / clear thresholds
//   avg_out          floor(window sum / DEPTH), registered
//   avg_valid        level, high once the window has filled
//   avg_stb          one-cycle pulse on each avg_out update
//   peak_out         maximum sample since reset or clr
//   alarm            hysteresis alarm
//   fill             samples held, saturating at DEPTH
module mag_window_stats
  import mag_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned MAG_W = mag_pkg::MAG_W,
  localparam int unsigned L     = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [MAG_W-1:0] thr_hi,
  input  logic [MAG_W-1:0] thr_lo,
  output logic [MAG_W-1:0] avg_out,
  output logic             avg_valid,
  output logic             avg_stb,
  output logic [MAG_W-1:0] peak_out,
  output logic             alarm,
  output logic [L:0]       fill
);

  localparam int unsigned SUM_W  = MAG_W + L;
  localparam int unsigned FILL_W = L + 1;

  state_t           state;
  logic [SUM_W-1:0] sum;
  logic [MAG_W-1:0] old_mag_c;
  logic [MAG_W-1:0] evict_c;
  logic [SUM_W-1:0] next_sum_c;
  logic [MAG_W-1:0] next_avg_c;
  logic             accept_c;
  logic             full_now_c;

  assign accept_c = in_valid && !clr;

  mag_ring_buf #(
    .DEPTH (DEPTH),
    .MAG_W (MAG_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_en     (accept_c),
    .wr_data   (in_mag),
    .old_mag_c (old_mag_c)
  );

  // Running sum update; buffer contents are ignored until the window is full.
  always_comb begin
    evict_c    = (state == RUN) ? old_mag_c : '0;
    next_sum_c = sum + SUM_W'(in_mag) - SUM_W'(evict_c);
    next_avg_c = MAG_W'(next_sum_c >> L);
    full_now_c = (state == RUN) || (fill == FILL_W'(DEPTH - 1));
  end

  // FSM, sum, fill, peak, mean and alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      sum       <= '0;
      fill      <= '0;
      peak_out  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      avg_stb   <= 1'b0;
      alarm     <= 1'b0;
    end else if (clr) begin
      state     <= FILL;
      sum       <= '0;
      fill      <= '0;
      peak_out  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      avg_stb   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      avg_stb <= 1'b0;
      if (accept_c) begin
        sum <= next_sum_c;
        if (in_mag > peak_out) peak_out <= in_mag;
        if (state == FILL) begin
          fill <= fill + FILL_W'(1);
          if (fill == FILL_W'(DEPTH - 1)) state <= RUN;
        end
        if (full_now_c) begin
          avg_out   <= next_avg_c;
          avg_stb   <= 1'b1;
          avg_valid <= 1'b1;
          // Set is tested first so it wins when thr_lo > thr_hi.
          if (next_avg_c > thr_hi)      alarm <= 1'b1;
          else if (next_avg_c < thr_lo) alarm <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mag_window_stats.sv
// Self-checking bench for mag_window_stats (DEPTH=8): a sample-queue model
// pushes expected outputs when a cycle is driven; they are popped and
// compared after the clock edge.
module tb_mag_window_stats;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAG_W = 8;

  typedef struct {
    int unsigned avg;
    bit          stb;
    bit          valid;
    int unsigned peak;
    bit          alarm;
    int unsigned fill;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic [MAG_W-1:0] in_mag;
  logic [MAG_W-1:0] thr_hi;
  logic [MAG_W-1:0] thr_lo;
  logic [MAG_W-1:0] avg_out;
  logic             avg_valid;
  logic             avg_stb;
  logic [MAG_W-1:0] peak_out;
  logic             alarm;
  logic [3:0]       fill;

  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t        sbq[$];
  int unsigned win[$];
  int unsigned m_peak, m_avg;
  bit          m_alarm, m_valid;

  mag_window_stats #(
    .DEPTH (DEPTH),
    .MAG_W (MAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_mag    (in_mag),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .avg_stb   (avg_stb),
    .peak_out  (peak_out),
    .alarm     (alarm),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_peak  = 0;
    m_avg   = 0;
    m_alarm = 0;
    m_valid = 0;
  endtask

  // Reference behaviour from the sample history, not from a running sum.
  task automatic model_step(input bit v, input int unsigned mag, input bit c, output exp_t e);
    int unsigned s;
    e.stb = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      win.push_back(mag);
      if (win.size() > DEPTH) void'(win.pop_front());
      if (mag > m_peak) m_peak = mag;
      if (win.size() == DEPTH) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_avg   = s / DEPTH;
        m_valid = 1;
        e.stb   = 1;
        if (m_avg > int'(thr_hi))      m_alarm = 1;
        else if (m_avg < int'(thr_lo)) m_alarm = 0;
      end
    end
    e.avg   = m_avg;
    e.valid = m_valid;
    e.peak  = m_peak;
    e.alarm = m_alarm;
    e.fill  = win.size();
  endtask

  task automatic step(input bit v, input int unsigned mag, input bit c);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_mag   = MAG_W'(mag);
    clr      = c;
    model_step(v, mag, c, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      check("avg_out",   avg_out,   e.avg);
      check("avg_stb",   avg_stb,   e.stb);
      check("avg_valid", avg_valid, e.valid);
      check("peak_out",  peak_out,  e.peak);
      check("alarm",     alarm,     e.alarm);
      check("fill",      fill,      e.fill);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_avg"},   avg_out,   0);
    check({tag, "_valid"}, avg_valid, 0);
    check({tag, "_stb"},   avg_stb,   0);
    check({tag, "_peak"},  peak_out,  0);
    check({tag, "_alarm"}, alarm,     0);
    check({tag, "_fill"},  fill,      0);
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_mag   = '0;
    thr_hi   = 8'd50;
    thr_lo   = 8'd30;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 10..80, then slide in 90 (wraps the pointer, evicts 10)
    for (int i = 1; i <= 8; i++) step(1, i * 10, 0);
    check("s1_avg45", avg_out, 45);
    check("s1_peak80", peak_out, 80);
    check("s1_fill8", fill, 8);
    check("s1_alarm_hold", alarm, 0);
    step(0, 123, 0);
    step(1, 90, 0);
    check("s2_avg55", avg_out, 55);
    check("s3_alarm_set", alarm, 1);

    // Hysteresis decay: 52,48,43,37,30 hold alarm, 21 clears it
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      if (i == 4) begin
        check("s3_avg30", avg_out, 30);
        check("s3_alarm_at30", alarm, 1);
      end
    end
    check("s3_avg21", avg_out, 21);
    check("s3_alarm_clr", alarm, 0);

    // Truncation and full-scale
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    step(1, 2, 0);
    check("s4_trunc", avg_out, 1);
    for (int i = 0; i < 8; i++) step(1, 255, 0);
    check("s4_full_scale", avg_out, 255);

    // clr together with a sample: sample dropped, everything cleared
    @(negedge clk);
    in_valid = 1'b1;
    in_mag   = 8'd200;
    clr      = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("s5_clr");
    clr = 1'b0;
    for (int i = 1; i <= 8; i++) step(1, i * 10, 0);
    check("s5_refill_avg", avg_out, 45);

    // Misconfigured thresholds: set wins
    thr_hi = 8'd10;
    thr_lo = 8'd200;
    step(1, 100, 0);
    check("misconf_set", alarm, 1);
    thr_hi = 8'd50;
    thr_lo = 8'd30;

    // Async reset mid-window after 5 samples
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 77, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("s6_async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 100, 0);
    check("s6_avg100", avg_out, 100);

    // Random traffic with idle cycles and occasional clr
    for (int i = 0; i < 200; i++) begin
      thr_hi = MAG_W'($urandom_range(255));
      thr_lo = MAG_W'($urandom_range(255));
      step(($urandom_range(3) != 0), $urandom_range(255), ($urandom_range(40) == 0));
    end

    check("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
